// File: rtl/algo_mt_pkg.sv
// Shared types and constants for the multi-read / multi-write map-table memory.
package algo_mt_pkg;

  typedef enum logic {
    MT_INIT = 1'b0,
    MT_RUN  = 1'b1
  } mt_state_t;

  localparam int unsigned MT_MAXDELAY = 4;

endpackage

// File: rtl/algo_mt_delay_pipe.sv
// Per-lane read-return delay line: carries valid plus data through DELAY register stages.
// Data is zeroed on entry when the lane is not valid, so idle lanes always present zero.
module algo_mt_delay_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] din,
  output logic             vld_out,
  output logic [WIDTH-1:0] dout
);

  logic [DELAY-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DELAY];
  logic [WIDTH-1:0] dat_d [DELAY];

  always_comb begin
    vld_d = '0;
    for (int unsigned i = 0; i < DELAY; i++) dat_d[i] = '0;
    vld_d[0] = vld_in;
    dat_d[0] = vld_in ? din : '0;
    for (int unsigned i = 1; i < DELAY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Reset flushes every in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DELAY; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int unsigned i = 0; i < DELAY; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign vld_out = vld_q[DELAY-1];
  assign dout    = dat_q[DELAY-1];

endmodule

// File: rtl/algo_mrnw_mt_mem.sv
// Multi-read / multi-write map-table memory with self-clearing init and pipelined reads.
// Optional macro MT_FWD_EN: same-edge write-to-read forwarding (default: reads return old data).
module algo_mrnw_mt_mem
  import algo_mt_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUMVROW = 2048,
  parameter int unsigned BITVROW = 11,
  parameter int unsigned NUMRDPT = 4,
  parameter int unsigned NUMWRPT = 2,
  parameter int unsigned DELAY   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic [NUMWRPT-1:0]         write,
  input  logic [NUMWRPT*BITVROW-1:0] wr_adr,
  input  logic [NUMWRPT*WIDTH-1:0]   din,
  input  logic [NUMRDPT-1:0]         read,
  input  logic [NUMRDPT*BITVROW-1:0] rd_adr,
  output logic [NUMRDPT-1:0]         rd_vld,
  output logic [NUMRDPT*WIDTH-1:0]   rd_dout,
  output logic                       wr_coll
);

  localparam int unsigned ROWW     = BITVROW + 1;
  localparam int unsigned MEMDEPTH = 1 << BITVROW;
  localparam logic [ROWW-1:0]    ROW_LIM  = ROWW'(NUMVROW);
  localparam logic [BITVROW-1:0] LAST_ROW = BITVROW'(NUMVROW - 1);

  if (DELAY < 1 || DELAY > MT_MAXDELAY) begin : g_bad_delay
    $fatal(1, "algo_mrnw_mt_mem: DELAY must be within 1..MT_MAXDELAY");
  end

  mt_state_t          state_q, state_d;
  logic [BITVROW-1:0] cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               coll_q, coll_d;

  logic [WIDTH-1:0]   mem_q [MEMDEPTH];

  logic [BITVROW-1:0] wa [NUMWRPT];
  logic [WIDTH-1:0]   wd [NUMWRPT];
  logic [BITVROW-1:0] ra [NUMRDPT];
  logic [NUMWRPT-1:0] wr_en_c;
  logic [NUMRDPT-1:0] rd_en_c;
  logic [WIDTH-1:0]   rd_dat_c [NUMRDPT];

  always_comb begin
    for (int unsigned p = 0; p < NUMWRPT; p++) begin
      wa[p] = wr_adr[p*BITVROW +: BITVROW];
      wd[p] = din[p*WIDTH +: WIDTH];
    end
    for (int unsigned l = 0; l < NUMRDPT; l++) ra[l] = rd_adr[l*BITVROW +: BITVROW];
  end

  // Init sweep clears one row per cycle, then the table stays in MT_RUN until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MT_INIT: begin
        cnt_d = cnt_q + BITVROW'(1);
        if (cnt_q == LAST_ROW) begin
          state_d = MT_RUN;
          cnt_d   = '0;
        end
      end
      MT_RUN:  state_d = MT_RUN;
      default: state_d = MT_INIT;
    endcase
    ready_d = (state_d == MT_RUN);
  end

  // Out-of-range writes are dropped and take no part in collision detection.
  always_comb begin
    wr_en_c = '0;
    coll_d  = 1'b0;
    for (int unsigned p = 0; p < NUMWRPT; p++)
      wr_en_c[p] = ready_q && write[p] && ({1'b0, wa[p]} < ROW_LIM);
    for (int unsigned p = 0; p < NUMWRPT; p++)
      for (int unsigned q = 0; q < NUMWRPT; q++)
        if (q > p && wr_en_c[p] && wr_en_c[q] && wa[p] == wa[q]) coll_d = 1'b1;
  end

  // Read lookup; later write ports override earlier ones when forwarding.
  always_comb begin
    rd_en_c = '0;
    for (int unsigned l = 0; l < NUMRDPT; l++) begin
      rd_en_c[l]  = ready_q && read[l];
      rd_dat_c[l] = ({1'b0, ra[l]} < ROW_LIM) ? mem_q[ra[l]] : '0;
`ifdef MT_FWD_EN
      for (int unsigned p = 0; p < NUMWRPT; p++)
        if (wr_en_c[p] && wa[p] == ra[l]) rd_dat_c[l] = wd[p];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MT_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      coll_q  <= coll_d;
    end
  end

  // Storage is cleared by the init sweep rather than by reset; highest write port lands last.
  always_ff @(posedge clk) begin
    if (state_q == MT_INIT) mem_q[cnt_q] <= '0;
    for (int unsigned p = 0; p < NUMWRPT; p++)
      if (wr_en_c[p]) mem_q[wa[p]] <= wd[p];
  end

  for (genvar l = 0; l < NUMRDPT; l++) begin : g_rd_lane
    algo_mt_delay_pipe #(
      .WIDTH (WIDTH),
      .DELAY (DELAY)
    ) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .vld_in  (rd_en_c[l]),
      .din     (rd_dat_c[l]),
      .vld_out (rd_vld[l]),
      .dout    (rd_dout[l*WIDTH +: WIDTH])
    );
  end

  assign ready   = ready_q;
  assign wr_coll = coll_q;

endmodule

// File: tb/tb_algo_mrnw_mt_mem.sv
// Randomized self-checking bench for algo_mrnw_mt_mem against a cycle-indexed reference model.
module tb_algo_mrnw_mt_mem;

  localparam int W   = 16;
  localparam int NR  = 16;
  localparam int BV  = 5;
  localparam int NRP = 4;
  localparam int NWP = 2;
  localparam int DLY = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ready;
  logic [NWP-1:0]   write = '0;
  logic [NWP*BV-1:0] wr_adr = '0;
  logic [NWP*W-1:0] din = '0;
  logic [NRP-1:0]   read = '0;
  logic [NRP*BV-1:0] rd_adr = '0;
  logic [NRP-1:0]   rd_vld;
  logic [NRP*W-1:0] rd_dout;
  logic             wr_coll;

  always #5 clk = ~clk;

  algo_mrnw_mt_mem #(
    .WIDTH(W), .NUMVROW(NR), .BITVROW(BV), .NUMRDPT(NRP), .NUMWRPT(NWP), .DELAY(DLY)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .write(write), .wr_adr(wr_adr), .din(din),
    .read(read), .rd_adr(rd_adr),
    .rd_vld(rd_vld), .rd_dout(rd_dout), .wr_coll(wr_coll)
  );

  typedef struct {
    int          due;
    int          lane;
    logic [15:0] d;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] mem_m [NR];
  int          cyc = 0;
  int          since_rst = 0;
  int          coll_due = -1;
  bit          m_ready = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic set_idle();
    write = '0; read = '0; wr_adr = '0; din = '0; rd_adr = '0;
  endtask

  task automatic wrp(input int p, input int a, input logic [15:0] d);
    write[p] = 1'b1;
    wr_adr[p*BV +: BV] = BV'(a);
    din[p*W +: W] = d;
  endtask

  task automatic rdp(input int l, input int a);
    read[l] = 1'b1;
    rd_adr[l*BV +: BV] = BV'(a);
  endtask

  task automatic randomize_inputs();
    set_idle();
    for (int p = 0; p < NWP; p++)
      if ($urandom_range(0, 1) == 1)
        wrp(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 19) : $urandom_range(0, 5),
            16'($urandom));
    for (int l = 0; l < NRP; l++)
      if ($urandom_range(0, 2) != 0)
        rdp(l, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 19) : $urandom_range(0, 5));
  endtask

  task automatic check_outputs();
    bit          ev;
    logic [15:0] ed;
    chk("ready", 32'(ready), 32'(m_ready));
    chk("wr_coll", 32'(wr_coll), 32'(coll_due == cyc));
    for (int l = 0; l < NRP; l++) begin
      ev = 1'b0;
      ed = '0;
      for (int i = 0; i < expq.size(); i++) begin
        if (expq[i].due == cyc && expq[i].lane == l) begin
          ev = 1'b1;
          ed = expq[i].d;
          expq.delete(i);
          break;
        end
      end
      chk($sformatf("rd_vld[%0d]", l), 32'(rd_vld[l]), 32'(ev));
      chk($sformatf("rd_dout[%0d]", l), 32'(rd_dout[l*W +: W]), 32'(ed));
    end
  endtask

  // Model one clock edge: reads see table contents from before this edge's writes.
  task automatic step();
    int          a;
    int          wa;
    int          nv;
    logic [15:0] d;
    logic [15:0] mem_n [NR];
    int          e;
    e = cyc + 1;
    mem_n = mem_m;
    if (m_ready) begin
      for (int l = 0; l < NRP; l++) begin
        if (read[l]) begin
          a = int'(rd_adr[l*BV +: BV]);
          d = (a < NR) ? mem_m[a] : 16'h0;
`ifdef MT_FWD_EN
          for (int p = 0; p < NWP; p++)
            if (write[p] && int'(wr_adr[p*BV +: BV]) == a && a < NR) d = din[p*W +: W];
`endif
          expq.push_back('{e + DLY - 1, l, d});
        end
      end
      for (int r = 0; r < NR; r++) begin
        nv = 0;
        for (int p = 0; p < NWP; p++)
          if (write[p] && int'(wr_adr[p*BV +: BV]) == r) nv++;
        if (nv >= 2) coll_due = e;
      end
      for (int p = 0; p < NWP; p++) begin
        wa = int'(wr_adr[p*BV +: BV]);
        if (write[p] && wa < NR) mem_n[wa] = din[p*W +: W];
      end
    end
    @(posedge clk);
    mem_m = mem_n;
    cyc++;
    since_rst++;
    m_ready = (since_rst >= NR);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int hold);
    set_idle();
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_vld", 32'(rd_vld), 32'd0);
    chk("rst_dout", 32'(rd_dout), 32'd0);
    chk("rst_coll", 32'(wr_coll), 32'd0);
    expq.delete();
    coll_due = -1;
    for (int r = 0; r < NR; r++) mem_m[r] = '0;
    repeat (hold) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("rst_hold_vld", 32'(rd_vld), 32'd0);
      chk("rst_hold_ready", 32'(ready), 32'd0);
    end
    rst = 1'b0;
    since_rst = 0;
    m_ready = 1'b0;
  endtask

  initial begin
    #2;
    do_reset(3);

    // Strobes during init must be ignored.
    repeat (NR) begin
      randomize_inputs();
      step();
    end

    for (int c = 0; c < NR / NRP; c++) begin
      set_idle();
      for (int l = 0; l < NRP; l++) rdp(l, c * NRP + l);
      step();
    end
    set_idle(); step(); step();

    wrp(0, 5, 16'hABCD); step();
    set_idle();
    for (int l = 0; l < NRP; l++) rdp(l, 5);
    step();
    set_idle(); step(); step();

    wrp(0, 7, 16'h1111); wrp(1, 7, 16'h2222); step();
    set_idle(); rdp(0, 7); step();
    set_idle(); step(); step();

    wrp(0, 3, 16'h0001); step();
    set_idle(); wrp(1, 3, 16'h0002); rdp(0, 3); step();
    set_idle(); rdp(1, 3); step();
    set_idle(); step(); step();

    rdp(0, 20); wrp(0, 20, 16'hFFFF); step();
    for (int c = 0; c < NR / NRP; c++) begin
      set_idle();
      for (int l = 0; l < NRP; l++) rdp(l, c * NRP + l);
      step();
    end
    set_idle(); step(); step();

    repeat (400) begin
      randomize_inputs();
      step();
    end

    // Reset with two reads still in the pipe.
    set_idle(); rdp(0, 5); rdp(1, 7); step();
    do_reset(2);
    repeat (NR + 4) begin
      randomize_inputs();
      step();
    end

    repeat (200) begin
      randomize_inputs();
      step();
    end
    set_idle();
    repeat (DLY + 2) step();

    chk("expq_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/algo_mrnw_mt_mem.md
ALGO_MRNW_MT_MEM -- requirements
Module: algo_mrnw_mt_mem

Interface
REQ-001 SHALL have parameter WIDTH, default 16: map-table entry width in bits.
REQ-002 SHALL have parameter NUMVROW, default 2048: number of rows.
REQ-003 SHALL have parameter BITVROW, default 11: row-address width.
REQ-004 SHALL have parameter NUMRDPT, default 4: number of read ports (>=1).
REQ-005 SHALL have parameter NUMWRPT, default 2: number of write ports (>=1).
REQ-006 SHALL have parameter DELAY, default 2: read latency in cycles (legal 1..4).
REQ-007 SHALL have port clk, input, 1: the single clock.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port ready, output, 1: init complete, ports accepted.
REQ-010 SHALL have port write, input, NUMWRPT: per-port write strobe.
REQ-011 SHALL have port wr_adr, input, NUMWRPT*BITVROW: packed write addresses, port 0 in the LSBs.
REQ-012 SHALL have port din, input, NUMWRPT*WIDTH: packed write data.
REQ-013 SHALL have port read, input, NUMRDPT: per-port read strobe.
REQ-014 SHALL have port rd_adr, input, NUMRDPT*BITVROW: packed read addresses.
REQ-015 SHALL have port rd_vld, output, NUMRDPT: per-port read data valid.
REQ-016 SHALL have port rd_dout, output, NUMRDPT*WIDTH: packed read data.
REQ-017 SHALL have port wr_coll, output, 1: same-address write collision flag.

Function
REQ-018 SHALL use FSM states MT_INIT and MT_RUN; reset enters MT_INIT with the row counter at 0.
REQ-019 In MT_INIT SHALL write 0 to row[counter] each cycle and increment the counter; after writing row NUMVROW-1 it SHALL enter MT_RUN on the next edge.
REQ-020 ready SHALL be 1 only in MT_RUN, giving a first ready cycle exactly NUMVROW cycles after reset release.
REQ-021 While ready=0, write and read strobes SHALL be ignored: no memory update, no rd_vld.
REQ-022 A write sampled at edge t SHALL update row[wr_adr] at edge t.
REQ-023 A read sampled at edge t SHALL drive rd_vld=1 and rd_dout exactly DELAY cycles later, on the same port lane.
REQ-024 Reads SHALL be fully pipelined: every port accepts a new read every cycle.
REQ-025 rd_dout SHALL be 0 on lanes with rd_vld=0.
REQ-026 Without forwarding, a read SHALL return the row contents before any write sampled on the same edge (old data).
REQ-027 When two or more write ports target the same address on one edge, the highest-numbered port SHALL win, and wr_coll SHALL pulse high for exactly one cycle, on the following cycle.
REQ-028 A write address >= NUMVROW SHALL be dropped; a read address >= NUMVROW SHALL return rd_vld=1 with rd_dout=0.
REQ-029 Multiple reads of the same address on one edge SHALL all return identical data.

Reset
REQ-030 Asserting rst SHALL asynchronously force ready=0, rd_vld=0, rd_dout=0, wr_coll=0, state=MT_INIT, counter=0, and SHALL flush all in-flight reads.
REQ-031 rst asserted mid-operation (either state) SHALL restart the full init sequence; memory contents SHALL NOT be relied upon until ready=1.

Configuration
REQ-032 Macro MT_FWD_EN defined: a read sampled on the same edge as a write to the same valid address SHALL return the new (winning) write data.
REQ-033 Macro MT_FWD_EN undefined: such a read SHALL return the old data, per REQ-026.

Structure
REQ-034 Package algo_mt_pkg SHALL hold typedef mt_state_t {MT_INIT, MT_RUN} and constant MT_MAXDELAY=4.
REQ-035 Sub-module algo_mt_delay_pipe SHALL implement the per-lane valid+data delay line of depth DELAY.
REQ-036 The design SHALL check DELAY against 1..MT_MAXDELAY at elaboration and SHALL fail elaboration on an illegal value.

Verification
REQ-037 Release reset with NUMVROW=16 -> ready rises on the 16th cycle after release; reading all rows returns 0.
REQ-038 Write row 5 = 0xABCD on port 0, then read row 5 on all 4 ports the next cycle -> all lanes return 0xABCD with rd_vld=1 exactly 2 cycles later.
REQ-039 Port 0 writes 0x1111 and port 1 writes 0x2222 to row 7 on the same edge -> row 7 = 0x2222; wr_coll=1 for one cycle on the next cycle.
REQ-040 Row 3 = 0x0001; on one edge write 0x0002 to row 3 and read row 3 -> 0x0002 with MT_FWD_EN defined, 0x0001 without it.
REQ-041 Assert rst while 2 reads are in flight -> rd_vld never pulses for them; ready=0 until the init sequence completes again.
REQ-042 Read address 20 with NUMVROW=16 -> rd_vld=1 and rd_dout=0; a write to address 20 leaves all rows unchanged.
